// File: rtl/alu_logic_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_logic_arbiter
//  Purpose  : Round-robin sharing of one registered logic unit between two
//             requesters, with a tagged valid/ready response channel.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_logic_arbiter #(
    parameter int A_WIDTH     = 5,
    parameter int B_WIDTH     = 5,
    parameter int LOGIC_WIDTH = 5,
    parameter int TIMEOUT     = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [1:0]               REQ_VALID,
    output logic [1:0]               REQ_READY,
    input  logic [2*A_WIDTH-1:0]     REQ_A,
    input  logic [2*B_WIDTH-1:0]     REQ_B,
    input  logic [3:0]               REQ_FUNC,
    output logic [A_WIDTH-1:0]       LU_A,
    output logic [B_WIDTH-1:0]       LU_B,
    output logic [1:0]               LU_FUNC,
    output logic                     LU_EN,
    input  logic [LOGIC_WIDTH-1:0]   LU_OUT,
    input  logic                     LU_FLAG,
    output logic                     RSP_VALID,
    input  logic                     RSP_READY,
    output logic                     RSP_ID,
    output logic [LOGIC_WIDTH-1:0]   RSP_DATA,
    output logic                     RSP_ERR,
    output logic                     BUSY
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   pri_q, pri_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [A_WIDTH-1:0]     a_q, a_d;
    logic [B_WIDTH-1:0]     b_q, b_d;
    logic [1:0]             func_q, func_d;
    logic                   id_q, id_d;
    logic [LOGIC_WIDTH-1:0] data_q, data_d;
    logic                   err_q, err_d;

    logic                   grant_valid;
    logic                   winner;

    // Priority holder wins if it is asking; otherwise the other requester.
    always_comb begin
        grant_valid = 1'b0;
        winner      = pri_q;
        if (REQ_VALID[pri_q]) begin
            grant_valid = 1'b1;
            winner      = pri_q;
        end else if (REQ_VALID[~pri_q]) begin
            grant_valid = 1'b1;
            winner      = ~pri_q;
        end
    end

    always_comb begin
        state_d = state_q;
        pri_d   = pri_q;
        timer_d = timer_q;
        a_d     = a_q;
        b_d     = b_q;
        func_d  = func_q;
        id_d    = id_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    a_d     = winner ? REQ_A[2*A_WIDTH-1:A_WIDTH] : REQ_A[A_WIDTH-1:0];
                    b_d     = winner ? REQ_B[2*B_WIDTH-1:B_WIDTH] : REQ_B[B_WIDTH-1:0];
                    func_d  = winner ? REQ_FUNC[3:2] : REQ_FUNC[1:0];
                    id_d    = winner;
                    pri_d   = ~winner;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (LU_FLAG) begin
                    data_d  = LU_OUT;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RESP: begin
                if (RSP_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            pri_q   <= 1'b0;
            timer_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            func_q  <= '0;
            id_q    <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
            timer_q <= timer_d;
            a_q     <= a_d;
            b_q     <= b_d;
            func_q  <= func_d;
            id_q    <= id_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Grant is gated by reset so nothing is offered while reset is held.
    assign REQ_READY = (RST && state_q == S_IDLE && grant_valid)
                       ? (winner ? 2'b10 : 2'b01) : 2'b00;
    assign LU_A      = a_q;
    assign LU_B      = b_q;
    assign LU_FUNC   = func_q;
    assign LU_EN     = (state_q == S_ISSUE);
    assign RSP_VALID = (state_q == S_RESP);
    assign RSP_ID    = id_q;
    assign RSP_DATA  = data_q;
    assign RSP_ERR   = err_q;
    assign BUSY      = (state_q != S_IDLE);

endmodule
`default_nettype wire
